// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory load controller.
//   IMEM_DEPTH / IMEM_WIDTH : default IMEM geometry (words / bits per word)
//   CNT_W                   : width of the shared clear/load counter and len
//   imem_state_t            : controller FSM state encoding
package imem_pkg;

  localparam int IMEM_DEPTH = 64;
  localparam int IMEM_WIDTH = 16;
  localparam int CNT_W      = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_FLUSH = 2'd3
  } imem_state_t;

endpackage

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller. IMEM is an external shift register of
// DEPTH words; every shift_enable cycle pushes new_value into IMEM[0].
// A load first shifts DEPTH zeros through the IMEM (CLEAR), then streams up to
// len source words in with a valid/ready handshake (LOAD), spends one cycle in
// FLUSH and pulses done on return to IDLE.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, len        load request and word count (1..DEPTH), taken in IDLE
//   abort             cancel an active operation (sets err)
//   in_valid/in_data  source word stream
//   in_ready          controller accepts a word (LOAD only)
//   shift_enable      registered IMEM shift strobe
//   new_value         registered word shifted into IMEM[0]
//   busy              any state other than IDLE
//   done              one-cycle completion pulse
//   err               sticky error (bad len or abort), cleared by a good start
//   loaded_count      words accepted in the current or last load
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int WIDTH = IMEM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             shift_enable,
  output logic [WIDTH-1:0] new_value,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] loaded_count
);

  localparam logic [CNT_W:0]   DEPTH_C    = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CLEAR = CNT_W'(DEPTH - 1);

  imem_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;
  logic             len_ok;
  logic             hs;

  assign len_ok = (len != '0) && ({1'b0, len} <= DEPTH_C);
  assign hs     = in_valid && in_ready;
  assign busy   = (state != ST_IDLE);

  // The counter tracks clear cycles while in CLEAR; hide that progress so
  // loaded_count reads as the freshly cleared word count.
  assign loaded_count = (state == ST_CLEAR) ? '0 : cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      len_q        <= '0;
      in_ready     <= 1'b0;
      shift_enable <= 1'b0;
      new_value    <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done         <= 1'b0;
      shift_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b0;
          if (start) begin
            if (len_ok) begin
              len_q        <= len;
              cnt          <= '0;
              err          <= 1'b0;
              state        <= ST_CLEAR;
              // First zero shift is issued in the cycle right after start.
              shift_enable <= 1'b1;
              new_value    <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          if (abort) begin
            state <= ST_IDLE;
            err   <= 1'b1;
            cnt   <= '0;
          end else if (cnt == LAST_CLEAR) begin
            state    <= ST_LOAD;
            in_ready <= 1'b1;
            cnt      <= '0;
          end else begin
            shift_enable <= 1'b1;
            new_value    <= '0;
            cnt          <= cnt + CNT_W'(1);
          end
        end
        ST_LOAD: begin
          if (abort) begin
            // A handshake coinciding with abort is dropped.
            state    <= ST_IDLE;
            err      <= 1'b1;
            in_ready <= 1'b0;
          end else if (hs && (cnt < len_q)) begin
            shift_enable <= 1'b1;
            new_value    <= in_data;
            cnt          <= cnt + CNT_W'(1);
            if ((cnt + CNT_W'(1)) == len_q) begin
              in_ready <= 1'b0;
              state    <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          in_ready <= 1'b0;
          state    <= ST_IDLE;
          if (abort) err  <= 1'b1;
          else       done <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Testbench for imem_load_ctrl: models the external IMEM shift register,
// pushes expected shift words into a scoreboard queue as stimulus is issued,
// and pops/compares them from a monitor whenever shift_enable is seen.
module tb_imem_load_ctrl;
  import imem_pkg::*;

  localparam int DEPTH = 64;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             abort;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             shift_enable;
  logic [WIDTH-1:0] new_value;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] loaded_count;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] words[$];
  logic [WIDTH-1:0] imem [DEPTH];
  int               done_cnt = 0;
  bit               se_seen  = 0;
  bit               busy_seen = 0;

  imem_load_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .shift_enable(shift_enable), .new_value(new_value), .busy(busy),
    .done(done), .err(err), .loaded_count(loaded_count)
  );

  always #5 clk = ~clk;

  // External IMEM model, reset by the same rst.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) imem[i] <= '0;
    end else if (shift_enable) begin
      for (int i = DEPTH - 1; i > 0; i--) imem[i] <= imem[i-1];
      imem[0] <= new_value;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_seen = 1;
      if (done) done_cnt++;
      if (shift_enable) begin
        se_seen = 1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_shift: got new_value %0h expected no shift", new_value);
        end else begin
          chk("shift_word", 32'(new_value), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] l);
    start = 1'b1;
    len   = l;
    if (l >= 1 && l <= DEPTH)
      for (int i = 0; i < DEPTH; i++) exp_q.push_back('0);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk(name, 32'(n), 32'(DEPTH));
  endtask

  task automatic send_words(input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      if (in_ready) exp_q.push_back(words[i]);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Called right after the final handshake edge.
  task automatic finish_check(input string name, input int n);
    int dc0 = done_cnt;
    chk({name, "_flush_ready"}, 32'(in_ready), 32'd0);
    chk({name, "_flush_busy"}, 32'(busy), 32'd1);
    tick();
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    chk({name, "_count"}, 32'(loaded_count), 32'(n));
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    tick();
    chk({name, "_done_once"}, 32'(done_cnt - dc0), 32'd1);
  endtask

  task automatic check_imem(input string name, input int n);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [WIDTH-1:0] e;
      e = (i < n) ? words[n-1-i] : '0;
      if (imem[i] !== e) bad++;
    end
    chk({name, "_imem_bad_entries"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int dc0, pushed, guard, bad;
    bit hs_prev;
    rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0;
    #1;
    chk("rst_shift_enable", 32'(shift_enable), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_count", 32'(loaded_count), 32'd0);
    chk("rst_new_value", 32'(new_value), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // len=3, back-to-back words
    words = '{16'h00A1, 16'h00B2, 16'h00C3};
    do_start(7'd3);
    chk("t1_busy_clear", 32'(busy), 32'd1);
    chk("t1_ready_clear", 32'(in_ready), 32'd0);
    wait_ready("t1_clear_cycles");
    send_words(0, 3);
    finish_check("t1", 3);
    check_imem("t1", 3);

    // len=64, in_valid toggling every other cycle
    words.delete();
    for (int k = 0; k < 64; k++) words.push_back(16'h1000 + 16'(k));
    do_start(7'd64);
    wait_ready("t2_clear_cycles");
    pushed = 0; guard = 0; bad = 0;
    while (pushed < 64 && guard < 400) begin
      in_valid = (guard % 2 == 0);
      in_data  = words[pushed];
      hs_prev  = in_valid && in_ready;
      if (hs_prev) begin
        exp_q.push_back(words[pushed]);
        pushed++;
      end
      tick();
      if (shift_enable !== hs_prev) bad++;
      guard++;
    end
    in_valid = 1'b0;
    chk("t2_words_accepted", 32'(pushed), 32'd64);
    chk("t2_shift_vs_handshake", 32'(bad), 32'd0);
    finish_check("t2", 64);
    check_imem("t2", 64);

    // Illegal lengths
    busy_seen = 0; se_seen = 0;
    do_start(7'd0);
    chk("t3_err_len0", 32'(err), 32'd1);
    tick();
    do_start(7'd65);
    chk("t3_err_len65", 32'(err), 32'd1);
    tick(); tick();
    chk("t3_busy_never", 32'(busy_seen), 32'd0);
    chk("t3_shift_never", 32'(se_seen), 32'd0);
    chk("t3_count_kept", 32'(loaded_count), 32'd64);

    // Abort on the 5th handshake of a len=10 load
    words.delete();
    for (int k = 0; k < 10; k++) words.push_back(16'h2000 + 16'(k));
    do_start(7'd10);
    chk("t4_err_cleared", 32'(err), 32'd0);
    wait_ready("t4_clear_cycles");
    send_words(0, 4);
    in_valid = 1'b1; in_data = words[4]; abort = 1'b1;
    dc0 = done_cnt;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_count", 32'(loaded_count), 32'd4);
    chk("t4_ready_low", 32'(in_ready), 32'd0);
    chk("t4_no_shift_on_abort", 32'(shift_enable), 32'd0);
    tick(); tick(); tick();
    chk("t4_no_done", 32'(done_cnt - dc0), 32'd0);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset 20 cycles into CLEAR, then a normal len=1 load
    do_start(7'd5);
    for (int k = 0; k < 20; k++) tick();
    rst = 1'b1;
    #1;
    chk("t5_rst_shift", 32'(shift_enable), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ready", 32'(in_ready), 32'd0);
    chk("t5_rst_err", 32'(err), 32'd0);
    chk("t5_rst_count", 32'(loaded_count), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    se_seen = 0;
    tick(); tick(); tick();
    chk("t5_no_shift_after_rst", 32'(se_seen), 32'd0);
    words = '{16'h005A};
    do_start(7'd1);
    wait_ready("t5_clear_cycles");
    send_words(0, 1);
    finish_check("t5", 1);
    check_imem("t5", 1);

    // start pulsed during LOAD is ignored
    words = '{16'h0D01, 16'h0D02, 16'h0D03, 16'h0D04};
    do_start(7'd4);
    wait_ready("t6_clear_cycles");
    send_words(0, 2);
    start = 1'b1; len = 7'd2;
    tick();
    start = 1'b0;
    chk("t6_count_kept", 32'(loaded_count), 32'd2);
    chk("t6_still_busy", 32'(busy), 32'd1);
    chk("t6_still_ready", 32'(in_ready), 32'd1);
    send_words(2, 4);
    finish_check("t6", 4);
    check_imem("t6", 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64: number of IMEM words, i.e. the shift-register length.
REQ-002 SHALL have parameter WIDTH, default 16: instruction word width.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset; asynchronous, active-high.
REQ-005 SHALL have port start, input, 1: load request; sampled only in IDLE.
REQ-006 SHALL have port len, input, 7: number of words to load; valid range 1..DEPTH.
REQ-007 SHALL have port abort, input, 1: cancel the current operation.
REQ-008 SHALL have port in_valid, input, 1: source word valid.
REQ-009 SHALL have port in_data, input, WIDTH: source instruction word.
REQ-010 SHALL have port in_ready, output, 1: controller accepts a word.
REQ-011 SHALL have port shift_enable, output, 1: IMEM shift strobe; registered.
REQ-012 SHALL have port new_value, output, WIDTH: word inserted at IMEM[0]; registered.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when a load completes.
REQ-015 SHALL have port err, output, 1: sticky error flag.
REQ-016 SHALL have port loaded_count, output, 7: words accepted in the current or last load.

Function
REQ-017 SHALL implement states IDLE, CLEAR, LOAD, FLUSH.
REQ-018 IDLE SHALL drive in_ready=0 and shift_enable=0.
REQ-019 SHALL, on start in IDLE with len in 1..DEPTH at edge T0: latch len, clear loaded_count and err, and enter CLEAR.
REQ-020 SHALL, on start in IDLE with len=0 or len>DEPTH: stay in IDLE, set err=1, issue no shift, and leave loaded_count unchanged.
REQ-021 CLEAR SHALL assert shift_enable=1 with new_value=0 for exactly DEPTH consecutive cycles, T0+1..T0+DEPTH, with in_ready=0, then enter LOAD.
REQ-022 LOAD SHALL drive in_ready=1; a handshake is in_valid and in_ready both high at an edge.
REQ-023 Each handshake at edge T SHALL produce shift_enable=1 with new_value=in_data during cycle T+1 and increment loaded_count; with no handshake, shift_enable SHALL be 0 on the next cycle.
REQ-024 Back-to-back handshakes SHALL be accepted every cycle with no bubbles.
REQ-025 SHALL, on the handshake that makes loaded_count equal the latched len: drop in_ready in the next cycle and enter FLUSH.
REQ-026 FLUSH SHALL last one cycle; in the following cycle done=1 and busy=0, and the state SHALL be IDLE.
REQ-027 After done, the first accepted word SHALL reside at IMEM[len-1] and the last at IMEM[0]; all other entries SHALL be 0.
REQ-028 SHALL, on abort in CLEAR, LOAD or FLUSH: enter IDLE at the next edge, set err=1, and never assert done.
REQ-029 SHALL discard a handshake in the same cycle as abort: no shift and no count increment.
REQ-030 SHALL ignore abort while in IDLE.
REQ-031 SHALL ignore start while busy=1.
REQ-032 loaded_count SHALL saturate at len and never exceed DEPTH.

Reset
REQ-033 SHALL, on rst: state=IDLE, shift_enable=0, new_value=0, in_ready=0, busy=0, done=0, err=0, loaded_count=0, latched len=0.
REQ-034 Reset mid-CLEAR or mid-LOAD SHALL abandon the operation immediately with no further shift_enable; IMEM is reset by the same rst.

Structure
REQ-035 Package imem_pkg SHALL hold IMEM_DEPTH=64, IMEM_WIDTH=16, the controller state enum, and the count width (7).
REQ-036 SHALL be a single module with no sub-module; one shared counter serves both the CLEAR cycle count and loaded_count.

Verification
REQ-037 Bench SHALL cover: rst, start len=3, words 0xA1,0xB2,0xC3 back-to-back -> 64 zero shifts, then 3 shifts; done 2 cycles after the last handshake; IMEM[2]=0xA1, IMEM[1]=0xB2, IMEM[0]=0xC3, rest 0.
REQ-038 Bench SHALL cover: start len=64 with in_valid toggling every other cycle -> exactly 64 data shifts, shift_enable low in bubble cycles, loaded_count=64, done once.
REQ-039 Bench SHALL cover: start len=0, then start len=65 -> err=1, busy never high, shift_enable never high.
REQ-040 Bench SHALL cover: len=10, abort coinciding with the 5th handshake -> loaded_count=4, err=1, IDLE next cycle, no done, 4 data shifts total.
REQ-041 Bench SHALL cover: rst asserted 20 cycles into CLEAR -> all outputs 0 immediately; a new start len=1 then completes normally.
REQ-042 Bench SHALL cover: start pulsed during LOAD -> ignored, latched len and count unaffected.
